// File: rtl/rename_map_nw.sv
// rename_map_nw: multi-lane register rename map with speculative RAT, retirement RAT and circular free list
module rename_map_nw #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int WIDTH = 2,
  parameter int ARCH_W = $clog2(ARCH_REGS),
  parameter int PHYS_W = $clog2(PHYS_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        rn_valid,
  output logic                    rn_ready,
  input  logic [WIDTH-1:0]        rn_uses_rd,
  input  logic [WIDTH*ARCH_W-1:0] rn_rd_arch,
  input  logic [WIDTH*ARCH_W-1:0] rn_rs1_arch,
  input  logic [WIDTH*ARCH_W-1:0] rn_rs2_arch,
  output logic [WIDTH*PHYS_W-1:0] rn_rs1_phys,
  output logic [WIDTH*PHYS_W-1:0] rn_rs2_phys,
  output logic [WIDTH*PHYS_W-1:0] rn_pd_new,
  output logic [WIDTH*PHYS_W-1:0] rn_pd_old,
  input  logic [WIDTH-1:0]        cm_valid,
  input  logic [WIDTH-1:0]        cm_uses_rd,
  input  logic [WIDTH*ARCH_W-1:0] cm_rd_arch,
  input  logic [WIDTH*PHYS_W-1:0] cm_pd_new,
  input  logic [WIDTH*PHYS_W-1:0] cm_pd_old,
  input  logic                    flush_valid,
  output logic [PHYS_W:0]         free_count,
  output logic                    recovering
);
  localparam int NFREE = PHYS_REGS - ARCH_REGS;
  localparam logic [PHYS_W:0] ONE = (PHYS_W+1)'(1);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t state_q, state_d;
  logic [PHYS_W-1:0] rat_q [ARCH_REGS];
  logic [PHYS_W-1:0] rat_d [ARCH_REGS];
  logic [PHYS_W-1:0] rrat_q [ARCH_REGS];
  logic [PHYS_W-1:0] rrat_d [ARCH_REGS];
  logic [PHYS_W-1:0] fl_q [PHYS_REGS];
  logic [PHYS_W-1:0] fl_d [PHYS_REGS];
  logic [PHYS_W:0] spec_head_q, spec_head_d, cmt_head_q, cmt_head_d, tail_q, tail_d, rn_ptr;
  logic [ARCH_W-1:0] rd_a [WIDTH];
  logic [PHYS_W-1:0] new_a [WIDTH];
  logic [WIDTH-1:0] rn_alloc;
  logic rn_fire;
  assign free_count = tail_q - spec_head_q;
  assign recovering = state_q == RECOVER;
  assign rn_ready = state_q == RUN && !flush_valid && free_count >= (PHYS_W+1)'(WIDTH);
  assign rn_fire = rn_ready && |rn_valid;
  // rename lookup: allocate tags in lane order and bypass from the youngest earlier lane writing the same rd
  always_comb begin
    rn_rs1_phys = '0;
    rn_rs2_phys = '0;
    rn_pd_new = '0;
    rn_pd_old = '0;
    rn_alloc = '0;
    rd_a = '{default: '0};
    new_a = '{default: '0};
    rn_ptr = spec_head_q;
    for (int j = 0; j < WIDTH; j++) begin
      rd_a[j] = rn_rd_arch[j*ARCH_W +: ARCH_W];
      rn_alloc[j] = rn_valid[j] && rn_uses_rd[j] && rd_a[j] != '0;
      new_a[j] = rn_alloc[j] ? fl_q[rn_ptr[PHYS_W-1:0]] : '0;
      rn_ptr = rn_alloc[j] ? rn_ptr + ONE : rn_ptr;
      rn_pd_new[j*PHYS_W +: PHYS_W] = new_a[j];
      rn_rs1_phys[j*PHYS_W +: PHYS_W] = rat_q[rn_rs1_arch[j*ARCH_W +: ARCH_W]];
      rn_rs2_phys[j*PHYS_W +: PHYS_W] = rat_q[rn_rs2_arch[j*ARCH_W +: ARCH_W]];
      rn_pd_old[j*PHYS_W +: PHYS_W] = rat_q[rd_a[j]];
      for (int k = 0; k < j; k++) begin
        if (rn_alloc[k] && rd_a[k] == rn_rs1_arch[j*ARCH_W +: ARCH_W]) rn_rs1_phys[j*PHYS_W +: PHYS_W] = new_a[k];
        if (rn_alloc[k] && rd_a[k] == rn_rs2_arch[j*ARCH_W +: ARCH_W]) rn_rs2_phys[j*PHYS_W +: PHYS_W] = new_a[k];
        if (rn_alloc[k] && rd_a[k] == rd_a[j]) rn_pd_old[j*PHYS_W +: PHYS_W] = new_a[k];
      end
      if (rn_rs1_arch[j*ARCH_W +: ARCH_W] == '0) rn_rs1_phys[j*PHYS_W +: PHYS_W] = '0;
      if (rn_rs2_arch[j*ARCH_W +: ARCH_W] == '0) rn_rs2_phys[j*PHYS_W +: PHYS_W] = '0;
    end
  end
  // next state: commits first, then renames, then a flush copies the post-commit RRAT over the RAT
  always_comb begin
    state_d = state_q == RUN && flush_valid ? RECOVER : RUN;
    rat_d = rat_q;
    rrat_d = rrat_q;
    fl_d = fl_q;
    tail_d = tail_q;
    cmt_head_d = cmt_head_q;
    spec_head_d = rn_fire ? rn_ptr : spec_head_q;
    for (int j = 0; j < WIDTH; j++) begin
      if (cm_valid[j] && cm_uses_rd[j] && cm_rd_arch[j*ARCH_W +: ARCH_W] != '0) begin
        rrat_d[cm_rd_arch[j*ARCH_W +: ARCH_W]] = cm_pd_new[j*PHYS_W +: PHYS_W];
        fl_d[tail_d[PHYS_W-1:0]] = cm_pd_old[j*PHYS_W +: PHYS_W];
        tail_d = tail_d + ONE;
        cmt_head_d = cmt_head_d + ONE;
      end
    end
    for (int j = 0; j < WIDTH; j++) if (rn_fire && rn_alloc[j]) rat_d[rd_a[j]] = new_a[j];
    if (state_d == RECOVER) begin
      rat_d = rrat_d;
      spec_head_d = cmt_head_d;
    end
  end
  // state registers with identity maps and the spare tags queued on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      spec_head_q <= '0;
      cmt_head_q <= '0;
      tail_q <= (PHYS_W+1)'(NFREE);
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PHYS_W'(i);
        rrat_q[i] <= PHYS_W'(i);
      end
      for (int k = 0; k < PHYS_REGS; k++) fl_q[k] <= k < NFREE ? PHYS_W'(ARCH_REGS + k) : '0;
    end else begin
      state_q <= state_d;
      spec_head_q <= spec_head_d;
      cmt_head_q <= cmt_head_d;
      tail_q <= tail_d;
      rat_q <= rat_d;
      rrat_q <= rrat_d;
      fl_q <= fl_d;
    end
  end
  // committed tags plus free tags always total the spare pool
  always_ff @(posedge clk) if (!rst) assert (tail_q - cmt_head_q == (PHYS_W+1)'(NFREE));
endmodule

// File: tb/tb_rename_map_nw.sv
// tb_rename_map_nw: scoreboard bench for rename_map_nw against a queue-based rename model
module tb_rename_map_nw;
  localparam int W = 2, AR = 32, AW = 5, PW = 6, NF = 32;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [W-1:0] rn_valid, rn_uses_rd, cm_valid, cm_uses_rd;
  logic rn_ready, flush_valid, recovering;
  logic [W*AW-1:0] rn_rd_arch, rn_rs1_arch, rn_rs2_arch, cm_rd_arch;
  logic [W*PW-1:0] rn_rs1_phys, rn_rs2_phys, rn_pd_new, rn_pd_old, cm_pd_new, cm_pd_old;
  logic [PW:0] free_count;
  rename_map_nw dut (
    .clk(clk), .rst(rst), .rn_valid(rn_valid), .rn_ready(rn_ready), .rn_uses_rd(rn_uses_rd),
    .rn_rd_arch(rn_rd_arch), .rn_rs1_arch(rn_rs1_arch), .rn_rs2_arch(rn_rs2_arch),
    .rn_rs1_phys(rn_rs1_phys), .rn_rs2_phys(rn_rs2_phys), .rn_pd_new(rn_pd_new), .rn_pd_old(rn_pd_old),
    .cm_valid(cm_valid), .cm_uses_rd(cm_uses_rd), .cm_rd_arch(cm_rd_arch), .cm_pd_new(cm_pd_new),
    .cm_pd_old(cm_pd_old), .flush_valid(flush_valid), .free_count(free_count), .recovering(recovering)
  );
  typedef struct packed {
    logic rdy;
    logic [PW:0] fc;
    logic rec;
    logic fire;
    logic [W-1:0] vld;
    logic [W-1:0] alloc;
    logic [W-1:0][PW-1:0] s1;
    logic [W-1:0][PW-1:0] s2;
    logic [W-1:0][PW-1:0] pn;
    logic [W-1:0][PW-1:0] po;
  } exp_t;
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [PW-1:0] pn;
    logic [PW-1:0] po;
  } rob_t;
  exp_t exp_q[$];
  exp_t m;
  rob_t rob[$];
  int rat[AR], rrat[AR];
  int cq[$];
  int nspec;
  bit rec;
  int checks = 0, failures = 0;
  logic [W-1:0] t_v, t_ur;
  int t_rd[W], t_s1[W], t_s2[W], t_cmn;
  bit t_dummy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < AR; i++) begin
      rat[i] = i;
      rrat[i] = i;
    end
    cq.delete();
    for (int k = 0; k < NF; k++) cq.push_back(AR + k);
    nspec = 0;
    rec = 0;
    rob.delete();
  endfunction

  task automatic set_grp(input logic [W-1:0] v, input logic [W-1:0] ur, input int a0, input int a1,
                         input int b0, input int b1, input int c0, input int c1, input int cmn);
    t_v = v; t_ur = ur;
    t_rd[0] = a0; t_rd[1] = a1;
    t_s1[0] = b0; t_s1[1] = b1;
    t_s2[0] = c0; t_s2[1] = c1;
    t_cmn = cmn; t_dummy = 0;
  endtask

  task automatic step(input bit fl, input bit r);
    exp_t e;
    int tmp[AR];
    int n;
    int nce;
    bit stop;
    rob_t ce[W];
    rob_t ne[$];
    e = '0;
    e.rdy = !rec && !fl && (NF - nspec) >= W;
    e.fc = (PW+1)'(NF - nspec);
    e.rec = rec;
    e.vld = t_v;
    e.fire = e.rdy && t_v != 0;
    tmp = rat;
    n = 0;
    for (int j = 0; j < W; j++) begin
      if (t_v[j]) begin
        e.s1[j] = t_s1[j] == 0 ? '0 : PW'(tmp[t_s1[j]]);
        e.s2[j] = t_s2[j] == 0 ? '0 : PW'(tmp[t_s2[j]]);
        e.po[j] = PW'(tmp[t_rd[j]]);
        if (t_ur[j] && t_rd[j] != 0) begin
          e.alloc[j] = 1;
          if (e.fire) begin
            e.pn[j] = PW'(cq[nspec + n]);
            tmp[t_rd[j]] = cq[nspec + n];
            ne.push_back('{rd: AW'(t_rd[j]), pn: e.pn[j], po: e.po[j]});
          end
          n++;
        end
      end
    end
    exp_q.push_back(e);
    rst = r;
    flush_valid = fl;
    rn_valid = t_v;
    rn_uses_rd = t_ur;
    for (int j = 0; j < W; j++) begin
      rn_rd_arch[j*AW +: AW] = AW'(t_rd[j]);
      rn_rs1_arch[j*AW +: AW] = AW'(t_s1[j]);
      rn_rs2_arch[j*AW +: AW] = AW'(t_s2[j]);
    end
    cm_valid = '0;
    cm_uses_rd = '0;
    cm_rd_arch = W*AW'($urandom);
    cm_pd_new = W*PW'($urandom);
    cm_pd_old = W*PW'($urandom);
    nce = 0;
    stop = 0;
    for (int j = 0; j < W; j++) begin
      if (!stop) begin
        if (j < t_cmn && rob.size() > 0) begin
          ce[nce] = rob.pop_front();
          cm_valid[j] = 1;
          cm_uses_rd[j] = 1;
          cm_rd_arch[j*AW +: AW] = ce[nce].rd;
          cm_pd_new[j*PW +: PW] = ce[nce].pn;
          cm_pd_old[j*PW +: PW] = ce[nce].po;
          nce++;
        end else begin
          if (t_dummy) begin
            cm_valid[j] = 1;
            cm_uses_rd[j] = 1'($urandom);
            if (cm_uses_rd[j]) cm_rd_arch[j*AW +: AW] = '0;
          end
          stop = 1;
        end
      end
    end
    if (r) model_reset();
    else begin
      for (int i = 0; i < nce; i++) begin
        rrat[ce[i].rd] = ce[i].pn;
        void'(cq.pop_front());
        cq.push_back(ce[i].po);
        nspec--;
      end
      if (e.fire) begin
        rat = tmp;
        nspec += n;
        foreach (ne[i]) rob.push_back(ne[i]);
      end
      if (!rec && fl) begin
        rat = rrat;
        nspec = 0;
        rob.delete();
        rec = 1;
      end else rec = 0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("rn_ready", rn_ready, m.rdy);
      chk("free_count", free_count, m.fc);
      chk("recovering", recovering, m.rec);
      if (m.fire && rn_ready) begin
        for (int j = 0; j < W; j++) begin
          if (m.vld[j]) begin
            chk($sformatf("rs1_phys[%0d]", j), rn_rs1_phys[j*PW +: PW], m.s1[j]);
            chk($sformatf("rs2_phys[%0d]", j), rn_rs2_phys[j*PW +: PW], m.s2[j]);
            chk($sformatf("pd_old[%0d]", j), rn_pd_old[j*PW +: PW], m.po[j]);
            if (m.alloc[j]) chk($sformatf("pd_new[%0d]", j), rn_pd_new[j*PW +: PW], m.pn[j]);
          end
        end
      end
    end
  end

  initial begin
    flush_valid = 0;
    rn_valid = '0; rn_uses_rd = '0; rn_rd_arch = '0; rn_rs1_arch = '0; rn_rs2_arch = '0;
    cm_valid = '0; cm_uses_rd = '0; cm_rd_arch = '0; cm_pd_new = '0; cm_pd_old = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    set_grp(2'b11, 2'b11, 5, 6, 1, 2, 3, 4, 0); step(0, 0);
    set_grp(2'b11, 2'b11, 7, 7, 9, 7, 0, 7, 0); step(0, 0);
    set_grp(2'b01, 2'b01, 0, 3, 5, 0, 7, 0, 0); step(0, 0);
    set_grp(2'b11, 2'b10, 4, 8, 4, 8, 5, 7, 0); step(0, 0);
    for (int i = 0; i < 16; i++) begin
      set_grp(2'b11, 2'b11, 1 + (i % 31), 2 + (i % 29), i, i + 1, 7, 5, 0);
      step(0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      set_grp(2'b11, 2'b11, 9, 10, 9, 10, 5, 6, 2);
      step(0, 0);
    end
    set_grp(2'b01, 2'b01, 5, 0, 5, 0, 0, 0, 0); step(0, 0);
    set_grp(2'b01, 2'b01, 5, 0, 5, 0, 0, 0, 1); step(1, 0);
    set_grp(2'b11, 2'b11, 5, 6, 5, 6, 0, 0, 1); step(1, 0);
    set_grp(2'b11, 2'b11, 5, 6, 5, 5, 6, 6, 0); step(0, 0);
    for (int i = 0; i < 5; i++) begin
      set_grp(2'b11, 2'b11, 11 + i, 20 + i, 5, 6, 11, 20, 0);
      step(0, 0);
    end
    set_grp(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0); step(1, 0);
    step(0, 1);
    set_grp(2'b11, 2'b11, 11, 20, 11, 20, 12, 21, 0); step(0, 0);
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 150) % 3;
      t_v = ($urandom % 4 == 0) ? 2'b00 : ($urandom % 3 == 0) ? 2'b01 : 2'b11;
      t_ur = 2'($urandom);
      for (int j = 0; j < W; j++) begin
        t_rd[j] = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 6);
        t_s1[j] = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 6);
        t_s2[j] = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 6);
      end
      t_cmn = ph == 0 ? int'($urandom % 3) : ph == 1 ? int'($urandom % 4 == 0) : 2;
      t_dummy = 1'($urandom);
      step($urandom % 40 == 0, $urandom % 400 == 0);
    end
    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
